// File: rtl/fp32_minmax_reduce.sv
// Streaming fp32 max/min reduction with argmax/argmin index, beat count and NaN tracking.
// One combinational fp32 comparator sits between the input beat and the running-best register.

module fp32_cmp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt,
    output logic        lt,
    output logic        unordered
);
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_eq;
    logic [31:0] w_key_a;
    logic [31:0] w_key_b;

    assign w_a_nan   = (&a[30:23]) && (|a[22:0]);
    assign w_b_nan   = (&b[30:23]) && (|b[22:0]);
    assign unordered = w_a_nan || w_b_nan;

    // Map IEEE bit patterns onto unsigned keys that sort in numeric order.
    assign w_key_a = a[31] ? ~a : {1'b1, a[30:0]};
    assign w_key_b = b[31] ? ~b : {1'b1, b[30:0]};

    // +0 and -0 compare equal even though their keys differ.
    assign w_eq = !unordered && ((a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)));
    assign gt   = !unordered && !w_eq && (w_key_a > w_key_b);
    assign lt   = !unordered && !w_eq && (w_key_a < w_key_b);
endmodule

module fp32_minmax_reduce #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_value,
    output logic [CNT_W-1:0] out_index,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_mode;
    logic [31:0]      r_best;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nan;
    logic             r_sat;

    logic             w_accept;
    logic             w_in_nan;
    logic             w_best_nan;
    logic             w_gt;
    logic             w_lt;
    logic             w_unord;
    logic             w_replace;
    logic [CNT_W-1:0] w_cnt_next;

    fp32_cmp u_cmp (
        .a         (in_data),
        .b         (r_best),
        .gt        (w_gt),
        .lt        (w_lt),
        .unordered (w_unord)
    );

    assign w_accept   = in_valid && in_ready;
    assign w_in_nan   = (&in_data[30:23]) && (|in_data[22:0]);
    assign w_best_nan = (&r_best[30:23]) && (|r_best[22:0]);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // Ties never replace, so the earliest of equal values keeps the index.
    assign w_replace = !w_in_nan &&
                       (w_best_nan || (!w_unord && (r_mode ? w_lt : w_gt)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (latch).
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b1;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_state_next = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_best <= 32'd0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_nan  <= 1'b0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_mode <= cfg_mode;
                r_best <= in_data;
                r_idx  <= '0;
                r_cnt  <= CNT_ONE;
                r_nan  <= w_in_nan;
                r_sat  <= (CNT_ONE == CNT_MAX);
            end else begin
                r_cnt <= w_cnt_next;
                if (w_cnt_next == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
                if (w_in_nan) begin
                    r_nan <= 1'b1;
                end
                // Once saturated r_cnt is all-ones, which is the stored index.
                if (w_replace) begin
                    r_best <= in_data;
                    r_idx  <= r_cnt;
                end
            end
        end
    end

    assign out_value = w_best_nan ? QNAN : r_best;
    assign out_index = w_best_nan ? '0 : r_idx;
    assign out_count = r_cnt;
    assign out_nan   = r_nan;
    assign out_sat   = r_sat;
endmodule

// File: tb/tb_fp32_minmax_reduce.sv
// Directed bench for fp32_minmax_reduce: max/min, NaN, ties, backpressure, reset, saturation.
// Inputs are driven and outputs sampled on the falling edge.

module tb_fp32_minmax_reduce;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [15:0] out_index;
    logic [15:0] out_count;
    logic        out_nan;
    logic        out_sat;

    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] in_data2;
    logic        in_last2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_value2;
    logic [1:0]  out_index2;
    logic [1:0]  out_count2;
    logic        out_nan2;
    logic        out_sat2;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_minmax_reduce #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mode  (cfg_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_index (out_index),
        .out_count (out_count),
        .out_nan   (out_nan),
        .out_sat   (out_sat)
    );

    fp32_minmax_reduce #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mode  (1'b0),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_last   (in_last2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_value (out_value2),
        .out_index (out_index2),
        .out_count (out_count2),
        .out_nan   (out_nan2),
        .out_sat   (out_sat2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one beat from a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [31:0] d, input logic last, input logic mode);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cfg_mode = mode;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] value,
                                 input logic [15:0] idx, input logic [15:0] cnt,
                                 input logic nan);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_value"}, out_value, value);
        check({tag, "_index"}, 32'(out_index), 32'(idx));
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        check({tag, "_nan"},   32'(out_nan), 32'(nan));
        check({tag, "_sat"},   32'(out_sat), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_mode   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = 32'd0;
        in_last2   = 1'b0;
        out_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_value",     out_value,      32'd0);
        check("rst_index",     32'(out_index), 32'd0);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_nan",       32'(out_nan),   32'd0);
        check("rst_sat",       32'(out_sat),   32'd0);

        // Max: 1.0, -2.0, 2.5, 0.5 -> 2.5 at index 2
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'hC000_0000, 1'b0, 1'b0);
        send(32'h4020_0000, 1'b0, 1'b0);
        send(32'h3F00_0000, 1'b1, 1'b0);
        expect_result("max4", 32'h4020_0000, 16'd2, 16'd4, 1'b0);

        // Min, with cfg_mode flipped after the first beat -> -2.0 at index 1
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'hC000_0000, 1'b0, 1'b0);
        send(32'h4020_0000, 1'b0, 1'b0);
        send(32'h3F00_0000, 1'b1, 1'b0);
        expect_result("min4", 32'hC000_0000, 16'd1, 16'd4, 1'b0);

        // Leading NaN is displaced; +inf wins at index 2
        send(32'h7FC0_0001, 1'b0, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h7F80_0000, 1'b1, 1'b0);
        expect_result("nan_lead", 32'h7F80_0000, 16'd2, 16'd3, 1'b1);

        // Single signalling NaN -> canonical quiet NaN
        send(32'h7FA0_0000, 1'b1, 1'b0);
        expect_result("nan_only", 32'h7FC0_0000, 16'd0, 16'd1, 1'b1);

        // Ties: +0 vs -0 vs +0 in max mode, earliest wins
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0);
        expect_result("tie_zero", 32'h0000_0000, 16'd0, 16'd3, 1'b0);

        // Equal ones in min mode; result held under backpressure
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h3F80_0000, 1'b1, 1'b1);
        check("tie_min_index", 32'(out_index), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h4080_0000;
        in_last  = 1'b1;
        cfg_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            check("bp_value",    out_value,      32'h3F80_0000);
            check("bp_count",    32'(out_count), 32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("bp_next", 32'h4080_0000, 16'd0, 16'd1, 1'b0);

        // Asynchronous reset mid-packet
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_value",     out_value,      32'd0);
        check("arst_count",     32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h4040_0000, 1'b1, 1'b0);
        expect_result("after_rst", 32'h4040_0000, 16'd0, 16'd1, 1'b0);

        // CNT_W = 2: five beats, winner arrives after saturation
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            in_data2  = (i == 1) ? 32'h4000_0000 :
                        (i == 4) ? 32'h40A0_0000 : 32'h3F80_0000;
            in_last2  = (i == 4);
            check("sat_in_ready", 32'(in_ready2), 32'd1);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        in_last2  = 1'b0;
        check("sat_valid", 32'(out_valid2), 32'd1);
        check("sat_value", out_value2,      32'h40A0_0000);
        check("sat_count", 32'(out_count2), 32'd3);
        check("sat_index", 32'(out_index2), 32'd3);
        check("sat_flag",  32'(out_sat2),   32'd1);
        check("sat_nan",   32'(out_nan2),   32'd0);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("sat_valid_drop", 32'(out_valid2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/fp32_minmax_reduce.md
Name: fp32_minmax_reduce

Overview:
Streaming reduction engine that finds the maximum or minimum of a packet of fp32 values, and its index, using one fp32_cmp instance. Input arrives on a valid/ready stream with a last marker. The block sequences the comparator against a running-best register and returns {value, index, count, nan flag} on a valid/ready result port. It sits between a vector producer and any top-k or argmax consumer.

Parameters:
CNT_W, 16, width of the element index and count fields.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_mode  in  1  0 = max, 1 = min; sampled on the first beat of each packet
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  32  fp32 element
in_last  in  1  final beat of the packet
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_value  out  32  winning fp32 value
out_index  out  CNT_W  0-based position of the winner in the packet
out_count  out  CNT_W  number of beats in the packet (saturating)
out_nan  out  1  at least one NaN was seen in the packet
out_sat  out  1  count saturated; index is invalid if it exceeds the saturation point

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). All registers clear immediately on reset assertion.
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0.
  - out_value = 0, out_index = 0, out_count = 0, out_nan = 0, out_sat = 0.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready = 1. On accept, latch mode ← cfg_mode. The first beat loads best ← in_data, best_idx ← 0, cnt ← 1, nan ← isNaN(in_data). Go to ACCUM, or to DONE if in_last.
  - ACCUM: in_ready = 1. Each accepted beat compares in_data (a) against best (b) through fp32_cmp. Go to DONE on an accepted in_last.
  - DONE: in_ready = 0, out_valid = 1, outputs held stable. On out_valid && out_ready, go to IDLE. Outputs keep their values but out_valid drops.
- Replacement rule, per accepted non-first beat:
  - If in_data is NaN: set nan; best is unchanged.
  - Else if best is NaN: replace.
  - Else for max mode, replace iff gt. For min mode, replace iff lt.
  - eq never replaces (earliest wins). This includes +0 vs −0.
  - On replace: best ← in_data, best_idx ← current cnt.
- Counting: cnt increments on each accepted beat and saturates at all-ones. Reaching saturation sets sat. Beats after saturation still take part in the comparison, but a replacing beat stores best_idx = all-ones.
- Result encoding:
  - If best is NaN at DONE (all elements NaN): out_value = 32'h7FC00000 and out_index = 0.
  - Otherwise out_value = best.
- Latency: a last beat accepted in cycle N gives out_valid = 1 in cycle N+1. No bubble on entry. After the result handshake in cycle M, in_ready = 1 in cycle M+1.
- Mode: cfg_mode changes after the first beat are ignored until the next packet.
- in_valid = 0 in ACCUM: hold state, no count change.
- Reset mid-packet: the partial result is discarded and the next accepted beat starts a new packet.
- Datapath: purely registered. The comparator is combinational between in_data and the best register. Throughput is 1 beat/cycle.

Test Plan:
- Max mode, stream 3F800000, C0000000, 40200000, 3F000000 (last) → out_value 40200000, index 2, count 4, nan 0, out_valid exactly 1 cycle after the last beat.
- Same stream, cfg_mode = 1 → out_value C0000000, index 1, count 4. Toggling cfg_mode mid-packet leaves the result unchanged.
- NaN handling, max mode:
  - 7FC00001, 3F800000, 7F800000 (last) → 7F800000, index 2, nan 1.
  - Single beat 7FA00000 (last) → 7FC00000, index 0, count 1, nan 1.
- Ties, max mode: 00000000, 80000000, 00000000 (last) → 00000000, index 0. Min mode with 3F800000, 3F800000 (last) → index 0.
- Backpressure: hold out_ready = 0 for 3 cycles after the result → outputs stable, in_ready = 0, and the offered next beat is not accepted. Raise out_ready → the next packet's first beat is accepted the cycle after the handshake.
- Reset: assert rst_n = 0 asynchronously mid-packet after 2 beats → out_valid 0, in_ready 1 immediately. A new 1-beat packet 40400000 (last) → value 40400000, count 1. With CNT_W = 2, a 5-beat packet → count 3, out_sat 1.
